washer_panel_ctrl: RTL and testbench

Front-panel command generator for the washer controller. It debounces the three raw panel keys (select, start, emergency stop) and tracks the selected wash mode. It produces the clean level signals the washer controller consumes: mode, start and active-low emergency. It also generates the 1 Hz second tick and drives the end-of-cycle beeper from the controller's done/alarm output.

---
 rtl/washer_pkg.sv | 27 ++
 rtl/washer_panel_ctrl_key_debounce.sv | 55 +++++
 rtl/washer_panel_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_washer_panel_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared definitions for the washer front panel and controller.
//   mode_e        : wash mode coding shared with the washer controller
//   panel_state_e : front-panel FSM states (3-bit codes visible on state_o)
//   ctr_w()       : counter width helper for 0..n-1 counters (minimum 1 bit)
package washer_pkg;

  typedef enum logic [1:0] {
    M_NONE  = 2'b00,
    M_RINSE = 2'b01,
    M_WASH  = 2'b10,
    M_SPIN  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ESTOP = 3'd4,
    S_PAUSE = 3'd5
  } panel_state_e;

  function automatic int unsigned ctr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/washer_panel_ctrl_key_debounce.sv
// key_debounce: synchroniser + debouncer for one active-low panel key.
//   clk, rst   : clock, asynchronous active-low reset
//   key_n      : raw asynchronous key, low = pressed
//   stable_o   : debounced key level (1 = released)
//   press_o    : one-clk pulse when the stable level falls 1->0
// Raw edge to press_o latency is 2 + DB_CYCLES clk cycles.
module key_debounce
  import washer_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CW = ctr_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      press_q <= 1'b0;
      if (sync2 == stable_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // DB_CYCLES-th consecutive differing sample: accept the new level
        stable_q <= sync2;
        press_q  <= stable_q;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/washer_panel_ctrl.sv
// washer_panel_ctrl: front-panel command generator for the washer controller.
//   clk, rst      : clock, asynchronous active-low reset
//   key_select_n  : raw mode-select key (low = pressed)
//   key_start_n   : raw start key (low = pressed)
//   key_estop_n   : raw emergency key (low = pressed)
//   done_i        : wash-complete/alarm level from the controller
//   mode_o        : selected mode (00 none, 01 rinse, 10 wash, 11 spin)
//   start_o       : run request level
//   estop_n_o     : emergency to controller, active-low
//   sec_tick_o    : one-clk pulse every TICK_DIV cycles
//   beep_o        : beeper drive
//   state_o       : FSM state (debug)
// Optional build macro PANEL_PAUSE_EN: start press in RUN pauses the cycle.
module washer_panel_ctrl
  import washer_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20,
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned BEEP_SEC  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_select_n,
  input  logic       key_start_n,
  input  logic       key_estop_n,
  input  logic       done_i,
  output logic [1:0] mode_o,
  output logic       start_o,
  output logic       estop_n_o,
  output logic       sec_tick_o,
  output logic       beep_o,
  output logic [2:0] state_o
);

  localparam int unsigned TW = ctr_w(TICK_DIV);
  localparam int unsigned BW = ctr_w(BEEP_SEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);

  logic sel_stable, sel_press;
  logic start_stable, start_press;
  logic estop_stable, estop_press;
  logic unused_keys;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_select (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_select_n),
    .stable_o (sel_stable),
    .press_o  (sel_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_start_n),
    .stable_o (start_stable),
    .press_o  (start_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_estop (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_estop_n),
    .stable_o (estop_stable),
    .press_o  (estop_press)
  );

  assign unused_keys = ^{sel_stable, start_stable, estop_press};

  // Free-running second tick, independent of the FSM
  logic [TW-1:0] tick_cnt;
  logic          tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      tick_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  // Registered compare of done_i gives the rising-edge detect
  logic done_q;
  logic done_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= done_i;
  end

  assign done_rise = done_i & ~done_q;

  panel_state_e  state, state_next;
  mode_e         mode_q, mode_next, mode_inc;
  logic [BW-1:0] beep_cnt, beep_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      mode_q   <= M_NONE;
      beep_cnt <= '0;
    end else begin
      state    <= state_next;
      mode_q   <= mode_next;
      beep_cnt <= beep_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    mode_next     = mode_q;
    beep_cnt_next = beep_cnt;
    mode_inc      = mode_e'(mode_q + 2'd1);

    if (!estop_stable) begin
      // Emergency overrides every other event in the same cycle
      state_next = S_ESTOP;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_press) begin
            mode_next  = M_RINSE;
            state_next = S_ARMED;
          end
        end
        S_ARMED: begin
          if (start_press) begin
            state_next = S_RUN;
          end else if (sel_press) begin
            mode_next = mode_inc;
            if (mode_inc == M_NONE) state_next = S_IDLE;
          end
        end
        S_RUN: begin
          if (done_rise) begin
            state_next    = S_DONE;
            beep_cnt_next = '0;
          end
`ifdef PANEL_PAUSE_EN
          else if (start_press) begin
            state_next = S_PAUSE;
          end
`endif
        end
        S_DONE: begin
          if (tick_q) begin
            if (beep_cnt == BEEP_LAST) begin
              state_next    = S_IDLE;
              mode_next     = M_NONE;
              beep_cnt_next = '0;
            end else begin
              beep_cnt_next = beep_cnt + 1'b1;
            end
          end
        end
        S_ESTOP: begin
          // Only reached with the stable key released
          if (start_press) begin
            state_next = S_IDLE;
            mode_next  = M_NONE;
          end
        end
`ifdef PANEL_PAUSE_EN
        S_PAUSE: begin
          if (start_press) state_next = S_RUN;
        end
`endif
        default: begin
          state_next = S_IDLE;
          mode_next  = M_NONE;
        end
      endcase
    end
  end

  assign mode_o     = mode_q;
  assign start_o    = (state == S_RUN);
  assign estop_n_o  = (state == S_ESTOP) ? estop_stable : 1'b1;
  assign beep_o     = (state == S_DONE);
  assign sec_tick_o = tick_q;
  assign state_o    = state;

endmodule

// File: tb/tb_washer_panel_ctrl.sv
// Self-checking bench for washer_panel_ctrl (DB_CYCLES=4, TICK_DIV=10,
// BEEP_SEC=3). Honours PANEL_PAUSE_EN when defined.
module tb_washer_panel_ctrl;

  localparam int DB = 4;
  localparam int TD = 10;
  localparam int BS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_select_n = 1'b1;
  logic       key_start_n  = 1'b1;
  logic       key_estop_n  = 1'b1;
  logic       done_i = 1'b0;
  logic [1:0] mode_o;
  logic       start_o;
  logic       estop_n_o;
  logic       sec_tick_o;
  logic       beep_o;
  logic [2:0] state_o;

  washer_panel_ctrl #(
    .DB_CYCLES (DB),
    .TICK_DIV  (TD),
    .BEEP_SEC  (BS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_select_n (key_select_n),
    .key_start_n  (key_start_n),
    .key_estop_n  (key_estop_n),
    .done_i       (done_i),
    .mode_o       (mode_o),
    .start_o      (start_o),
    .estop_n_o    (estop_n_o),
    .sec_tick_o   (sec_tick_o),
    .beep_o       (beep_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // key: 0 select, 1 start, 2 select+start together
  task automatic press(input int key);
    if (key == 0 || key == 2) key_select_n = 1'b0;
    if (key == 1 || key == 2) key_start_n  = 1'b0;
    cyc(10);
    key_select_n = 1'b1;
    key_start_n  = 1'b1;
    cyc(10);
  endtask

  typedef struct {
    int    key;
    int    exp_mode;
    int    exp_state;
    int    exp_start;
    string name;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  found;

    tbl[0] = '{0, 1, 1, 0, "sel1"};
    tbl[1] = '{0, 2, 1, 0, "sel2"};
    tbl[2] = '{0, 3, 1, 0, "sel3"};
    tbl[3] = '{0, 0, 0, 0, "sel_wrap"};
    tbl[4] = '{1, 0, 0, 0, "start_idle"};
    tbl[5] = '{0, 1, 1, 0, "sel_again1"};
    tbl[6] = '{0, 2, 1, 0, "sel_again2"};

    // Reset state
    cyc(3);
    chk("rst_mode",  int'(mode_o), 0);
    chk("rst_start", int'(start_o), 0);
    chk("rst_estop", int'(estop_n_o), 1);
    chk("rst_tick",  int'(sec_tick_o), 0);
    chk("rst_beep",  int'(beep_o), 0);
    chk("rst_state", int'(state_o), 0);
    rst = 1'b1;
    cyc(2);

    // One-cycle glitch must not register
    key_select_n = 1'b0;
    cyc(1);
    key_select_n = 1'b1;
    cyc(12);
    chk("glitch_mode",  int'(mode_o), 0);
    chk("glitch_state", int'(state_o), 0);

    // Mode selection table
    for (int i = 0; i < 7; i++) begin
      press(tbl[i].key);
      chk({tbl[i].name, "_mode"},  int'(mode_o),  tbl[i].exp_mode);
      chk({tbl[i].name, "_state"}, int'(state_o), tbl[i].exp_state);
      chk({tbl[i].name, "_start"}, int'(start_o), tbl[i].exp_start);
    end

    // Start latency: press pulse after 6 edges, RUN after 7
    key_start_n = 1'b0;
    cyc(6);
    chk("start_lat6", int'(start_o), 0);
    cyc(1);
    chk("start_lat7", int'(start_o), 1);
    cyc(3);
    key_start_n = 1'b1;
    cyc(10);
    chk("run_state", int'(state_o), 2);
    chk("run_mode",  int'(mode_o), 2);

    // Raise done_i in a tick cycle so DONE spans exactly BS*TD cycles
    found = 0;
    for (int i = 0; i < 2 * TD && !found; i++) begin
      @(negedge clk);
      if (sec_tick_o) found = 1;
    end
    chk("tick_seen", int'(found), 1);
    done_i = 1'b1;
    @(negedge clk);
    chk("done_state", int'(state_o), 3);
    chk("done_start", int'(start_o), 0);
    chk("done_beep",  int'(beep_o), 1);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (beep_o) n++;
      else break;
    end
    chk("beep_len",     n, BS * TD);
    chk("after_state",  int'(state_o), 0);
    chk("after_mode",   int'(mode_o), 0);
    done_i = 1'b0;
    cyc(2);

    // Emergency stop from RUN
    press(0);
    press(1);
    chk("run2_start", int'(start_o), 1);
    key_estop_n = 1'b0;
    cyc(6);
    chk("estop_lat6", int'(estop_n_o), 1);
    cyc(1);
    chk("estop_lat7", int'(estop_n_o), 0);
    chk("estop_start", int'(start_o), 0);
    chk("estop_state", int'(state_o), 4);
    press(1);
    chk("estop_held_state", int'(state_o), 4);
    chk("estop_held_n",     int'(estop_n_o), 0);
    key_estop_n = 1'b1;
    cyc(10);
    chk("estop_rel_n",     int'(estop_n_o), 1);
    chk("estop_rel_state", int'(state_o), 4);
    press(1);
    chk("estop_exit_state", int'(state_o), 0);
    chk("estop_exit_mode",  int'(mode_o), 0);
    chk("estop_exit_n",     int'(estop_n_o), 1);

    // Simultaneous select + start in ARMED: start wins
    press(0);
    press(2);
    chk("both_state", int'(state_o), 2);
    chk("both_mode",  int'(mode_o), 1);
    chk("both_start", int'(start_o), 1);

    // Asynchronous reset mid-RUN
    rst = 1'b0;
    #1;
    chk("arst_mode",  int'(mode_o), 0);
    chk("arst_start", int'(start_o), 0);
    chk("arst_estop", int'(estop_n_o), 1);
    chk("arst_tick",  int'(sec_tick_o), 0);
    chk("arst_beep",  int'(beep_o), 0);
    chk("arst_state", int'(state_o), 0);
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // Start press while running
    press(0);
    press(1);
    chk("run3_start", int'(start_o), 1);
    press(1);
`ifdef PANEL_PAUSE_EN
    chk("pause_start", int'(start_o), 0);
    chk("pause_state", int'(state_o), 5);
    chk("pause_mode",  int'(mode_o), 1);
    press(1);
    chk("resume_start", int'(start_o), 1);
    chk("resume_state", int'(state_o), 2);
`else
    chk("nopause_start", int'(start_o), 1);
    chk("nopause_state", int'(state_o), 2);
    chk("nopause_mode",  int'(mode_o), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
